// File: rtl/servo_pkg.sv
// Shared opcode encodings, command FSM states and instruction field widths
// for the servo command executor.
package servo_pkg;

  localparam int OPCODE_W  = 2;
  localparam int OPERAND_W = 8;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] OP_SET  = 2'b00;
  localparam logic [OPCODE_W-1:0] OP_INC  = 2'b01;
  localparam logic [OPCODE_W-1:0] OP_DEC  = 2'b10;
  localparam logic [OPCODE_W-1:0] OP_HOME = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/servo_pwm_gen.sv
// Frame counter, rate-limited position slew and glitch-free PWM pulse
// generator. The pulse width is reloaded only at the frame boundary.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int FRAME_CYC = 1_000_000,
  parameter int MIN_CYC   = 50_000,
  parameter int STEP_CYC  = 277,
  parameter int HOME_POS  = 90,
  parameter int RATE      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] target_pos,
  output logic [OPERAND_W-1:0] position,
  output logic                 pwm_out,
  output logic                 frame_tick
);

  localparam int CNT_W = $clog2(FRAME_CYC);
  localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0]     MIN_P      = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0]     STEP_P     = CNT_W'(STEP_CYC);
  localparam logic [CNT_W-1:0]     HOME_PULSE = CNT_W'(MIN_CYC + HOME_POS * STEP_CYC);
  localparam logic [OPERAND_W-1:0] HOME_P     = OPERAND_W'(HOME_POS);
  localparam logic [OPERAND_W-1:0] RATE_P     = OPERAND_W'(RATE);

  logic [CNT_W-1:0]     frame_cnt;
  logic [CNT_W-1:0]     pulse_cyc;
  logic [OPERAND_W-1:0] diff;
  logic [OPERAND_W-1:0] step;
  logic [OPERAND_W-1:0] pos_next;

  assign frame_tick = (frame_cnt == LAST_CNT);

  always_comb begin
    if (target_pos > position) diff = target_pos - position;
    else                       diff = position - target_pos;
    step = (diff > RATE_P) ? RATE_P : diff;
    if (target_pos > position) pos_next = position + step;
    else                       pos_next = position - step;
  end

  // The pulse width is loaded from the freshly slewed position at the wrap,
  // so a slew step shows up on pwm_out in the very next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      position  <= HOME_P;
      pulse_cyc <= HOME_PULSE;
      pwm_out   <= 1'b0;
    end else begin
      pwm_out <= (frame_cnt < pulse_cyc);
      if (frame_tick) begin
        frame_cnt <= '0;
        position  <= pos_next;
        pulse_cyc <= MIN_P + CNT_W'(pos_next) * STEP_P;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/servo_cmd_exec.sv
// Servo command executor: edge-detects a ready level from the instruction
// receiver, executes SET/INC/DEC/HOME on the target, and drives the PWM slice.
module servo_cmd_exec
  import servo_pkg::*;
#(
  parameter int FRAME_CYC = 1_000_000,
  parameter int MIN_CYC   = 50_000,
  parameter int STEP_CYC  = 277,
  parameter int MAX_POS   = 180,
  parameter int HOME_POS  = 90,
  parameter int RATE      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instruction,
  input  logic                 instruction_ready,
  output logic                 instr_ack,
  output logic                 pwm_out,
  output logic [OPERAND_W-1:0] position,
  output logic [OPERAND_W-1:0] target_pos,
  output logic                 busy,
  output logic                 clamped,
  output logic                 frame_tick
);

  if (FRAME_CYC <= MIN_CYC + MAX_POS * STEP_CYC) begin : g_cfg_check
    $error("servo_cmd_exec: FRAME_CYC must exceed the widest pulse");
  end

  localparam logic [8:0]           MAX_P9 = 9'(MAX_POS);
  localparam logic [OPERAND_W-1:0] MAX_P  = OPERAND_W'(MAX_POS);
  localparam logic [OPERAND_W-1:0] HOME_P = OPERAND_W'(HOME_POS);

  cmd_state_t           state;
  logic                 ready_q;
  logic                 ready_rise;
  logic [INSTR_W-1:0]   instr_q;
  logic [OPCODE_W-1:0]  opcode;
  logic [8:0]           operand9;
  logic [8:0]           target9;
  logic [8:0]           sum9;
  logic [OPERAND_W-1:0] target_next;
  logic                 clamp_next;

  assign ready_rise = instruction_ready & ~ready_q;
  assign opcode     = instr_q[INSTR_W-1:OPERAND_W];
  assign operand9   = {1'b0, instr_q[OPERAND_W-1:0]};
  assign target9    = {1'b0, target_pos};
  assign busy       = (position != target_pos);

  // clamped flags true saturation: the unbounded result would leave 0..MAX_POS
  always_comb begin
    target_next = target_pos;
    clamp_next  = 1'b0;
    sum9        = target9 + operand9;
    case (opcode)
      OP_SET: begin
        if (operand9 > MAX_P9) begin
          target_next = MAX_P;
          clamp_next  = 1'b1;
        end else begin
          target_next = instr_q[OPERAND_W-1:0];
        end
      end
      OP_INC: begin
        if (sum9 > MAX_P9) begin
          target_next = MAX_P;
          clamp_next  = 1'b1;
        end else begin
          target_next = sum9[OPERAND_W-1:0];
        end
      end
      OP_DEC: begin
        if (target9 > operand9) begin
          target_next = target_pos - instr_q[OPERAND_W-1:0];
        end else begin
          target_next = '0;
          clamp_next  = (operand9 > target9);
        end
      end
      default: target_next = HOME_P;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      instr_q    <= '0;
      target_pos <= HOME_P;
      instr_ack  <= 1'b0;
      clamped    <= 1'b0;
    end else begin
      ready_q   <= instruction_ready;
      instr_ack <= 1'b0;
      clamped   <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_rise) begin
            instr_q <= instruction;
            state   <= EXEC;
          end
        end
        EXEC: begin
          target_pos <= target_next;
          instr_ack  <= 1'b1;
          clamped    <= clamp_next;
          state      <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  servo_pwm_gen #(
    .FRAME_CYC (FRAME_CYC),
    .MIN_CYC   (MIN_CYC),
    .STEP_CYC  (STEP_CYC),
    .HOME_POS  (HOME_POS),
    .RATE      (RATE)
  ) u_pwm (
    .clk        (clk),
    .reset      (reset),
    .target_pos (target_pos),
    .position   (position),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

endmodule

// File: tb/tb_servo_cmd_exec.sv
// Self-checking bench for servo_cmd_exec: per-cycle comparison against a
// behavioural model plus directed literal checks of the key scenarios.
module tb_servo_cmd_exec;

  localparam int FRAME_CYC = 400;
  localparam int MIN_CYC   = 20;
  localparam int STEP_CYC  = 1;
  localparam int MAX_POS   = 180;
  localparam int HOME_POS  = 90;
  localparam int RATE      = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] instruction = '0;
  logic       instruction_ready = 1'b0;
  logic       instr_ack, pwm_out, busy, clamped, frame_tick;
  logic [7:0] position, target_pos;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  servo_cmd_exec #(
    .FRAME_CYC (FRAME_CYC), .MIN_CYC (MIN_CYC), .STEP_CYC (STEP_CYC),
    .MAX_POS (MAX_POS), .HOME_POS (HOME_POS), .RATE (RATE)
  ) dut (
    .clk (clk), .reset (reset), .instruction (instruction),
    .instruction_ready (instruction_ready), .instr_ack (instr_ack),
    .pwm_out (pwm_out), .position (position), .target_pos (target_pos),
    .busy (busy), .clamped (clamped), .frame_tick (frame_tick)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int cmd_target(input logic [9:0] cmd, input int tgt);
    int opnd;
    opnd = int'(cmd[7:0]);
    case (cmd[9:8])
      2'd0:    return (opnd > MAX_POS) ? MAX_POS : opnd;
      2'd1:    return (tgt + opnd > MAX_POS) ? MAX_POS : tgt + opnd;
      2'd2:    return (tgt > opnd) ? tgt - opnd : 0;
      default: return HOME_POS;
    endcase
  endfunction

  function automatic bit cmd_clamp(input logic [9:0] cmd, input int tgt);
    int opnd;
    opnd = int'(cmd[7:0]);
    case (cmd[9:8])
      2'd0:    return opnd > MAX_POS;
      2'd1:    return tgt + opnd > MAX_POS;
      2'd2:    return opnd > tgt;
      default: return 1'b0;
    endcase
  endfunction

  int         m_phase, m_pulse, m_pos, m_tgt;
  bit         m_pwm, m_ack, m_clp, m_prev_rdy;
  bit         model_valid = 1'b0;
  int         edge_n = 0;
  int         free_edge = 0;
  int         exec_edge = -1;
  logic [9:0] m_cmd;

  // Time-based view: a command seen at edge n executes at n+1 and the
  // executor can take a new one from edge n+3 on.
  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      m_phase = 0; m_pos = HOME_POS; m_tgt = HOME_POS;
      m_pulse = MIN_CYC + HOME_POS * STEP_CYC;
      m_pwm = 0; m_ack = 0; m_clp = 0; m_prev_rdy = 0;
      free_edge = edge_n + 1; exec_edge = -1;
      model_valid = 1'b1;
    end else begin
      m_pwm = (m_phase < m_pulse);
      if (m_phase == FRAME_CYC - 1) begin
        if (m_pos < m_tgt)      m_pos += (m_tgt - m_pos > RATE) ? RATE : m_tgt - m_pos;
        else if (m_pos > m_tgt) m_pos -= (m_pos - m_tgt > RATE) ? RATE : m_pos - m_tgt;
        m_pulse = MIN_CYC + m_pos * STEP_CYC;
        m_phase = 0;
      end else begin
        m_phase++;
      end
      m_ack = 0; m_clp = 0;
      if (edge_n == exec_edge) begin
        m_clp = cmd_clamp(m_cmd, m_tgt);
        m_tgt = cmd_target(m_cmd, m_tgt);
        m_ack = 1;
      end
      if (instruction_ready && !m_prev_rdy && edge_n >= free_edge) begin
        m_cmd = instruction;
        exec_edge = edge_n + 1;
        free_edge = edge_n + 3;
      end
      m_prev_rdy = instruction_ready;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_position",   int'(position),   m_pos);
      check("cyc_target_pos", int'(target_pos), m_tgt);
      check("cyc_busy",       int'(busy),       int'(m_pos != m_tgt));
      check("cyc_instr_ack",  int'(instr_ack),  int'(m_ack));
      check("cyc_clamped",    int'(clamped),    int'(m_clp));
      check("cyc_frame_tick", int'(frame_tick), int'(m_phase == FRAME_CYC - 1));
      check("cyc_pwm_out",    int'(pwm_out),    int'(m_pwm));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send_cmd(input logic [9:0] cmd, input int exp_tgt, input int exp_clp);
    int lat;
    bit got;
    @(negedge clk);
    instruction = cmd;
    instruction_ready = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (instr_ack) got = 1;
    end
    check("ack_latency", got ? lat : -1, 2);
    check("cmd_target",  int'(target_pos), exp_tgt);
    check("cmd_clamped", int'(clamped),    exp_clp);
    @(negedge clk);
    instruction_ready = 1'b0;
  endtask

  task automatic count_pwm_frame(input string name, input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    check(name, hi, exp);
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 2 * FRAME_CYC);
    if (!frame_tick) check(name, 0, 1);
  endtask

  initial begin
    int ticks, guard, acks, first_step;

    // 1: reset values and home pulse width
    repeat (3) @(negedge clk);
    check("rst_position",  int'(position),   90);
    check("rst_target",    int'(target_pos), 90);
    check("rst_busy",      int'(busy),       0);
    check("rst_ack",       int'(instr_ack),  0);
    check("rst_pwm",       int'(pwm_out),    0);
    check("rst_frame_cnt", int'(dut.u_pwm.frame_cnt), 0);
    reset = 1'b0;
    count_pwm_frame("home_pulse_width", 110);
    count_pwm_frame("home_pulse_width2", 110);

    // 2: SET 180 and full ramp
    send_cmd(10'h0B4, 180, 0);
    ticks = 0; guard = 0; first_step = -1;
    while (guard < 30 * FRAME_CYC) begin
      @(negedge clk);
      guard++;
      if (!busy) break;
      if (ticks == 1 && first_step < 0) first_step = int'(position);
      if (frame_tick) ticks++;
    end
    check("ramp_first_step", first_step, 94);
    check("ramp_tick_count", ticks, 23);
    check("ramp_final_pos",  int'(position), 180);
    count_pwm_frame("max_pulse_width", 200);

    // 3: saturation cases
    send_cmd(10'h0C8, 180, 1);
    send_cmd(10'h01E, 30,  0);
    send_cmd(10'h232, 0,   1);
    send_cmd(10'h0AA, 170, 0);
    send_cmd(10'h164, 180, 1);
    send_cmd(10'h3FF, 90,  0);

    // 4: level held high executes once
    @(negedge clk);
    instruction = 10'h00A;
    instruction_ready = 1'b1;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ack) acks++;
    end
    check("held_ready_acks",   acks, 1);
    check("held_ready_target", int'(target_pos), 10);
    @(negedge clk);
    instruction_ready = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(10'h014, 20, 0);

    // 5: target written on the frame_tick edge
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    wait_tick("tick_wait_a");
    repeat (FRAME_CYC - 1) @(negedge clk);
    instruction = 10'h0B4;
    instruction_ready = 1'b1;
    @(negedge clk);
    check("tick_write_on_tick", int'(frame_tick), 1);
    @(negedge clk);
    check("tick_old_target_pos", int'(position),   90);
    check("tick_new_target",     int'(target_pos), 180);
    instruction_ready = 1'b0;
    wait_tick("tick_wait_b");
    @(negedge clk);
    check("tick_next_frame_pos", int'(position), 94);

    // 6: reset mid-ramp and mid-EXEC
    repeat (7) @(negedge clk);
    instruction = 10'h005;
    instruction_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    instruction_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_position",  int'(position),   90);
    check("mid_rst_target",    int'(target_pos), 90);
    check("mid_rst_frame_cnt", int'(dut.u_pwm.frame_cnt), 0);
    check("mid_rst_ack",       int'(instr_ack),  0);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (instr_ack) acks++;
    end
    check("mid_rst_no_ack", acks, 0);

    // 7: random ready toggling, commands and occasional resets
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 5) == 0) instruction_ready = ~instruction_ready;
      if (!instruction_ready) instruction = 10'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    instruction_ready = 1'b0;
    repeat (2 * FRAME_CYC) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/servo_cmd_exec.md
# servo_cmd_exec

Consumes each 10-bit command from the serial instruction receiver, executes it against a target servo position, and drives a 50 Hz-frame PWM output whose pulse width tracks the current position. The current position slews toward the target at a bounded rate per frame. `instr_ack` feeds back to the receiver's `reset` input so the receiver can accept the next command.

## Interface
- `FRAME_CYC`, default 1_000_000: clock cycles per PWM frame.
- `MIN_CYC`, default 50_000: pulse width in cycles at position 0.
- `STEP_CYC`, default 277: extra pulse cycles per position unit.
- `MAX_POS`, default 180: highest legal position.
- `HOME_POS`, default 90: reset and HOME position.
- `RATE`, default 4: maximum position change per frame.
- Elaboration check: `FRAME_CYC` > `MIN_CYC` + `MAX_POS`*`STEP_CYC`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `instruction` in 10: bits [9:8] are the opcode, bits [7:0] are the operand.
- `instruction_ready` in 1: level from the receiver; stays high until the receiver is reset.
- `instr_ack` out 1: one-cycle pulse after a command executes.
- `pwm_out` out 1: servo drive, registered.
- `position` out 8: current position.
- `target_pos` out 8: commanded position.
- `busy` out 1: high while `position` != `target_pos`.
- `clamped` out 1: one-cycle pulse, coincident with `instr_ack`, when the result saturated.
- `frame_tick` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- Rising-edge detect on `instruction_ready` uses a `ready_q` register that updates every cycle. Edges seen outside IDLE are dropped. A level held high never re-triggers.
- Command FSM has three states:
  - IDLE: on an edge, latch `instruction` and go to EXEC.
  - EXEC: update `target_pos`, go to ACK.
  - ACK: `instr_ack`=1 (plus `clamped` if applicable), go to IDLE.
- Opcodes (9-bit intermediate arithmetic):
  - 00 SET: target = min(operand, MAX_POS).
  - 01 INC: target = min(target+operand, MAX_POS).
  - 10 DEC: target = target > operand ? target−operand : 0.
  - 11 HOME: target = HOME_POS; operand ignored.
- `clamped`=1 when a min or 0-floor was applied, or the SET operand exceeded MAX_POS.
- Frame counter `frame_cnt` runs 0..FRAME_CYC−1 and wraps. `frame_tick` is high when `frame_cnt` = FRAME_CYC−1.
- Slew on each `frame_tick` cycle:
  - If position < target: position += min(RATE, target−position).
  - If position > target: position −= min(RATE, position−target).
  - Otherwise position is unchanged.
- `pulse_cyc` = MIN_CYC + position*STEP_CYC. It is registered when `frame_cnt` wraps to 0, so the width is constant within a frame (no glitching).
- `pwm_out` next = (`frame_cnt` < `pulse_cyc`).

## Timing
- Reset values:
  - `target_pos` = `position` = HOME_POS.
  - `frame_cnt` = 0, FSM = IDLE, `ready_q` = 0.
  - `pwm_out`, `instr_ack`, `clamped`, `frame_tick`, `busy` = 0.
  - `pulse_cyc` = MIN_CYC + HOME_POS*STEP_CYC.
- Command latency: the first edge sampling `instruction_ready`=1 latches the command. `target_pos` updates one edge later. `instr_ack` is high during the following cycle, i.e. 2 cycles after latch, for exactly 1 cycle.
- `pwm_out` lags `frame_cnt` by one cycle. The high phase is exactly `pulse_cyc` cycles per frame.
- A target write in the same cycle as `frame_tick`: slew uses the old target; the new target acts from the next frame.
- A new position takes effect on `pwm_out` in the frame after the slew step.
- Reset mid-command or mid-ramp: all state returns to reset values on the next edge. A pending command is discarded with no `instr_ack`.
- Reset takes priority over all other events.

## Structure
- Package `servo_pkg` holds:
  - opcode constants `OP_SET`, `OP_INC`, `OP_DEC`, `OP_HOME`;
  - FSM state enum `IDLE`/`EXEC`/`ACK`;
  - the `instruction` field widths.
- Sub-module `servo_pwm_gen` contains the frame counter, slew register, `pulse_cyc` register and comparator. It takes `target_pos` as input and outputs `position`, `pwm_out` and `frame_tick`.
- The top level holds the edge detect, command FSM and target arithmetic.

## Test plan
Bench parameters: FRAME_CYC=400, MIN_CYC=20, STEP_CYC=1, MAX_POS=180, HOME_POS=90, RATE=4.

1. Release reset -> `position`=90; `pwm_out` high for exactly 110 of every 400 cycles; `busy`=0.
2. Send `instruction`=10'h0B4 (SET 180) -> one `instr_ack` 2 cycles after latch; `target_pos`=180; position steps 94, 98, …, 178, 180 (23 frames); final pulse 200 cycles; `busy` drops at 180.
3. Send SET 200 (10'h0C8) -> `target_pos`=180 with `clamped`=1. Then DEC 50 from target 30 -> 0 with `clamped`=1. Then INC 100 from 170 -> 180 with `clamped`=1. Then HOME -> 90 with `clamped`=0.
4. Hold `instruction_ready` high 50 cycles -> exactly one `instr_ack` and one target update. Drop it, raise it again -> a second execution.
5. Write a target on the `frame_tick` cycle -> that frame's slew uses the old target; the new one applies from the next tick.
6. Assert reset mid-ramp and mid-EXEC -> next cycle `position`=`target_pos`=90, `frame_cnt`=0, no `instr_ack`.
